tdm_scanner: RTL and testbench
==============================

TDM_SCANNER -- requirements
Module: tdm_scanner

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1, cycles each select value is held before sampling; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request one 4-bit scan; sampled in IDLE only.
REQ-005 SHALL have port continuous  input  1  when 1, the next scan begins automatically after each handshake.
REQ-006 SHALL have port mux_out  input  1  serial bit returned by the downstream 4:1 mux.
REQ-007 SHALL have port select_lines  output  2  drives the mux select; registered.
REQ-008 SHALL have port frame  output  4  last completed frame; registered.
REQ-009 SHALL have port frame_valid  output  1  frame holds an unconsumed result.
REQ-010 SHALL have port frame_ready  input  1  consumer accepts frame when high with frame_valid.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port overrun  output  1  sticky; start seen while busy.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-014 SHALL, in IDLE with start=1 at edge E0, enter SCAN with select_lines=00 and hold counter=0.
REQ-015 SHALL, in SCAN, increment the hold counter each cycle and sample mux_out when it reaches HOLD_CYCLES-1, then clear the counter.
REQ-016 SHALL map samples to frame bits: select 00->bit3, 01->bit2, 10->bit1, 11->bit0.
REQ-017 SHALL, after a sample with select_lines<11, advance select_lines by 1 on the same edge.
REQ-018 SHALL, on the sample edge with select_lines=11, load all 4 bits into frame, set frame_valid=1, and enter DONE.
REQ-019 The last sample SHALL therefore occur at edge E0+4*HOLD_CYCLES, with frame_valid visible in the following cycle.
REQ-020 SHALL accumulate partial bits in an internal shift register; frame SHALL change only on frame completion.
REQ-021 SHALL drive select_lines=00 in IDLE and DONE.
REQ-022 SHALL, in DONE, hold frame and frame_valid stable until an edge with frame_ready=1.
REQ-023 SHALL, at the handshake edge, clear frame_valid and enter SCAN (counter=0, select 00) if continuous=1, else IDLE.
REQ-024 SHALL ignore frame_ready when frame_valid=0.
REQ-025 SHALL ignore start in SCAN and DONE and set overrun=1 if start=1 there; overrun SHALL clear only by reset.
REQ-026 start and continuous SHALL be don't-care at the handshake edge except as stated in REQ-023; start in IDLE on the cycle after returning to IDLE SHALL be honoured.

Reset
REQ-027 SHALL, on an edge with rst_n=0, force state IDLE, select_lines=00, frame=0000, frame_valid=0, busy=0, overrun=0, counter and shift register=0.
REQ-028 Reset mid-SCAN or mid-DONE SHALL discard the partial or pending frame without asserting frame_valid.

Structure
REQ-029 A shared package SHALL hold the state enum, the select-to-bit-position mapping, and the HOLD_CYCLES legal bounds.
REQ-030 The hold counter SHALL be one sub-module, settle_timer (4-bit, clear/enable, terminal-count output).

Verification
REQ-031 HOLD=1, start pulse, mux_out driven as 1,0,1,1 per select 00..11 -> frame=1011 and frame_valid high at E0+5; select sequence 00,01,10,11.
REQ-032 HOLD=3, mux_out=in[3-sel] of pattern 0110 -> each select held 3 cycles; frame=0110; frame_valid asserted exactly at E0+12+1.
REQ-033 frame_ready held low 10 cycles after completion -> frame and frame_valid stable; overrun=1 after a start pulse in DONE; handshake returns to IDLE.
REQ-034 continuous=1, frame_ready=1 -> back-to-back frames 1000,0100,0010,0001; busy never drops; select restarts at 00 after each handshake.
REQ-035 rst_n low at select=10 mid-SCAN -> next cycle all outputs are reset values, frame_valid never pulses, and a fresh start yields a correct frame.

Source files
------------

// File: rtl/tdm_scanner_pkg.sv
// rtl/tdm_scanner_pkg.sv - shared types, select-to-bit mapping and hold bounds for the TDM scanner
package tdm_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 15;

  // Select 00 lands in the MSB so the frame reads in scan order.
  function automatic logic [1:0] sel_to_bit(input logic [1:0] sel);
    return 2'd3 - sel;
  endfunction

  // Out-of-range hold values are clamped rather than wrapping the 4-bit timer.
  function automatic logic [3:0] hold_terminal(input int hold);
    if (hold < HOLD_MIN) return 4'd0;
    else if (hold > HOLD_MAX) return 4'(HOLD_MAX - 1);
    else return 4'(hold - 1);
  endfunction

endpackage

// File: rtl/tdm_scanner_settle_timer.sv
// rtl/tdm_scanner_settle_timer.sv - 4-bit settle counter with clear/enable and terminal-count flag
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] terminal,
  output logic       tc
);

  logic [3:0] count;

  assign tc = (count == terminal);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/tdm_scanner.sv
// rtl/tdm_scanner.sv - walks a 4:1 mux select, samples its output and presents 4-bit frames with valid/ready
module tdm_scanner
  import tdm_scanner_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       mux_out,
  output logic [1:0] select_lines,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy,
  output logic       overrun
);

  localparam logic [3:0] TERMINAL = hold_terminal(HOLD_CYCLES);

  state_t     state;
  logic [3:0] shreg;
  logic [3:0] shreg_next;
  logic       tc;
  logic       in_scan;

  assign in_scan = (state == ST_SCAN);
  assign busy    = (state != ST_IDLE);

  settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!in_scan || tc),
    .enable   (in_scan),
    .terminal (TERMINAL),
    .tc       (tc)
  );

  always_comb begin
    shreg_next = shreg;
    shreg_next[sel_to_bit(select_lines)] = mux_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      select_lines <= 2'b00;
      frame        <= 4'b0000;
      frame_valid  <= 1'b0;
      overrun      <= 1'b0;
      shreg        <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          select_lines <= 2'b00;
          if (start) begin
            state <= ST_SCAN;
            shreg <= 4'b0000;
          end
        end
        ST_SCAN: begin
          if (start) overrun <= 1'b1;
          if (tc) begin
            shreg <= shreg_next;
            if (select_lines == 2'b11) begin
              frame        <= shreg_next;
              frame_valid  <= 1'b1;
              select_lines <= 2'b00;
              state        <= ST_DONE;
            end else begin
              select_lines <= select_lines + 2'b01;
            end
          end
        end
        ST_DONE: begin
          select_lines <= 2'b00;
          // start is a don't-care on the handshake edge itself.
          if (frame_ready) begin
            frame_valid <= 1'b0;
            shreg       <= 4'b0000;
            state       <= continuous ? ST_SCAN : ST_IDLE;
          end else if (start) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          select_lines <= 2'b00;
          frame_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_scanner.sv
// tb/tb_tdm_scanner.sv - self-checking bench for tdm_scanner (HOLD 1 and HOLD 3 instances)
module tb_tdm_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, continuous, frame_ready, mux_out;
  logic [1:0] select_lines;
  logic [3:0] frame;
  logic       frame_valid, busy, overrun;
  logic [3:0] pattern;

  logic       start3, ready3, mux3;
  logic [1:0] sel3;
  logic [3:0] frame3;
  logic       fv3, busy3, ovr3;
  logic [3:0] pattern3;

  int passed = 0;
  int total  = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [3:0] pat;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  assign mux_out = pattern[~select_lines];
  assign mux3    = pattern3[~sel3];

  tdm_scanner #(.HOLD_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .mux_out(mux_out), .select_lines(select_lines), .frame(frame),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy),
    .overrun(overrun)
  );

  tdm_scanner #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .continuous(1'b0),
    .mux_out(mux3), .select_lines(sel3), .frame(frame3),
    .frame_valid(fv3), .frame_ready(ready3), .busy(busy3),
    .overrun(ovr3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic scan_one(input logic [3:0] pat, input logic [3:0] exp, input string tag);
    int n;
    logic [3:0] want;
    pattern = pat;
    start = 1'b1;
    exp_q.push_back(exp);
    tick();
    start = 1'b0;
    n = 0;
    while (!frame_valid && n < 40) begin
      if (n < 4) check({tag, "_sel"}, {30'd0, select_lines}, n);
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 4);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    check({tag, "_frame"}, {28'd0, frame}, {28'd0, want});
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check({tag, "_handshake"}, {30'd0, frame_valid, busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic busy_ok;
    vecs[0] = '{pat: 4'b1011, exp: 4'b1011};
    vecs[1] = '{pat: 4'b0000, exp: 4'b0000};
    vecs[2] = '{pat: 4'b1111, exp: 4'b1111};
    vecs[3] = '{pat: 4'b0110, exp: 4'b0110};
    vecs[4] = '{pat: 4'b1001, exp: 4'b1001};

    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; frame_ready = 1'b0;
    pattern = 4'b0000; start3 = 1'b0; ready3 = 1'b0; pattern3 = 4'b0000;
    tick(); tick();
    check("reset_outputs", {24'd0, select_lines, frame, frame_valid, busy, overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) scan_one(vecs[i].pat, vecs[i].exp, $sformatf("vec%0d", i));

    // HOLD=3: each select held 3 cycles, valid one cycle after E0+12
    pattern3 = 4'b0110;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 0;
    while (!fv3 && n < 60) begin
      if (n < 12) check($sformatf("hold3_sel_%0d", n), {30'd0, sel3}, n / 3);
      tick();
      n++;
    end
    check("hold3_latency", n, 12);
    check("hold3_frame", {28'd0, frame3}, 32'b0110);
    ready3 = 1'b1;
    tick();
    ready3 = 1'b0;
    check("hold3_handshake", {30'd0, fv3, busy3}, 32'd0);

    // Consumer stalls; frame stays put and start in DONE is flagged
    pattern = 4'b1100;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!frame_valid && n < 40) begin tick(); n++; end
    check("stall_overrun_clear", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall_hold_%0d", i), {27'd0, frame_valid, frame}, {27'd0, 1'b1, 4'b1100});
      if (i == 4) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("stall_overrun_set", {30'd0, overrun, busy}, 32'b11);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("stall_to_idle", {29'd0, frame_valid, busy, overrun}, 32'b001);

    // Continuous back-to-back frames
    continuous = 1'b1;
    frame_ready = 1'b1;
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
    pattern = 4'b1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_ok = 1'b1;
    for (int f = 0; f < 4; f++) begin
      n = 0;
      while (!frame_valid && n < 40) begin
        if (!busy) busy_ok = 1'b0;
        tick();
        n++;
      end
      check($sformatf("cont_frame_%0d", f), {28'd0, frame},
            {28'd0, (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx});
      pattern = 4'b1000 >> (f + 1);
      if (f == 3) continuous = 1'b0;
      tick();
      if (f < 3) begin
        check($sformatf("cont_restart_%0d", f), {29'd0, select_lines, frame_valid}, 32'd0);
        if (!busy) busy_ok = 1'b0;
      end
    end
    check("cont_busy_held", {31'd0, busy_ok}, 32'd1);
    check("cont_end_idle", {31'd0, busy}, 32'd0);
    frame_ready = 1'b0;

    // Reset mid-scan at select 10
    pattern = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (select_lines != 2'b10 && n < 20) begin tick(); n++; end
    check("midscan_reached_sel2", {30'd0, select_lines}, 32'b10);
    rst_n = 1'b0;
    tick();
    check("midscan_reset", {24'd0, select_lines, frame, frame_valid, busy, overrun}, 32'd0);
    rst_n = 1'b1;
    busy_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (frame_valid || busy) busy_ok = 1'b0;
      tick();
    end
    check("midscan_no_pulse", {31'd0, busy_ok}, 32'd1);
    scan_one(4'b1010, 4'b1010, "after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
